// File: rtl/mem_init_pkg.sv
// Shared state encoding and default geometry for the mem_initiator request master.
package mem_init_pkg;

  localparam int DEF_ADDR_W = 4;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_LEN_W  = 4;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD_ADDR,
    RD_CAP,
    RSP
  } state_t;

endpackage

// File: rtl/mem_initiator.sv
// Request-side master for the 16x8 single-port memory; hides its registered read latency.
// Optional MEM_INIT_WRITE_ACK_EN: writes return a one-beat ack on the response channel.
module mem_initiator
  import mem_init_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_write,
  output logic              rsp_last,
  output logic              mem_wr_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  localparam logic [ADDR_W-1:0] ONE_ADDR = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [LEN_W-1:0]  ONE_LEN  = {{(LEN_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [LEN_W-1:0]  beats_left;

`ifdef MEM_INIT_WRITE_ACK_EN
  logic              wack;
  assign rsp_write = wack;
`else
  assign rsp_write = 1'b0;
`endif

  // mem_addr doubles as the burst address register; it only moves on accept or beat handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      req_ready     <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_last      <= 1'b0;
      mem_wr_enable <= 1'b0;
      mem_addr      <= '0;
      mem_data_in   <= '0;
      beats_left    <= '0;
`ifdef MEM_INIT_WRITE_ACK_EN
      wack          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            mem_addr  <= req_addr;
            if (req_write) begin
              mem_wr_enable <= 1'b1;
              mem_data_in   <= req_wdata;
              state         <= WR;
            end else begin
              beats_left <= req_len;
              state      <= RD_ADDR;
            end
          end
        end
        WR: begin
          mem_wr_enable <= 1'b0;
`ifdef MEM_INIT_WRITE_ACK_EN
          rsp_valid <= 1'b1;
          rsp_rdata <= mem_data_in;
          rsp_last  <= 1'b1;
          wack      <= 1'b1;
          state     <= RSP;
`else
          req_ready <= 1'b1;
          state     <= IDLE;
`endif
        end
        RD_ADDR: state <= RD_CAP;
        // Memory output now reflects the address presented during RD_ADDR.
        RD_CAP: begin
          rsp_valid <= 1'b1;
          rsp_rdata <= mem_data_out;
          rsp_last  <= (beats_left == '0);
`ifdef MEM_INIT_WRITE_ACK_EN
          wack      <= 1'b0;
`endif
          state     <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rsp_last) begin
              req_ready <= 1'b1;
              state     <= IDLE;
            end else begin
              beats_left <= beats_left - ONE_LEN;
              mem_addr   <= mem_addr + ONE_ADDR;
              state      <= RD_ADDR;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
